writeback: RTL and testbench

Final (W) stage of the five-stage Y86-64 pipeline: holds the W pipeline register and drives the register-file write ports and W-stage forwarding sources consumed by decode. It suppresses register writes for faulting instructions, freezes the pipeline's architectural end on halt or exception, reports processor status, and keeps retired-instruction and cycle counters.

---
 rtl/writeback_pkg.sv | 61 ++++++
 rtl/wb_perf_cnt.sv | 34 +++
 rtl/writeback.sv | 150 +++++++++++++++
 tb/tb_writeback.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_pkg
//  Description : Shared Y86-64 constants for the write-back stage: status
//                codes, icodes, register IDs, the W pipeline-register record
//                and the bubble value loaded on reset or bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_pkg;

    // Status codes
    localparam logic [2:0] c_SBUB = 3'd0;
    localparam logic [2:0] c_SAOK = 3'd1;
    localparam logic [2:0] c_SHLT = 3'd2;
    localparam logic [2:0] c_SADR = 3'd3;
    localparam logic [2:0] c_SINS = 3'd4;

    // Instruction codes
    localparam logic [3:0] c_IHALT   = 4'h0;
    localparam logic [3:0] c_INOP    = 4'h1;
    localparam logic [3:0] c_IRRMOVQ = 4'h2;
    localparam logic [3:0] c_IIRMOVQ = 4'h3;
    localparam logic [3:0] c_IRMMOVQ = 4'h4;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_IJXX    = 4'h7;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    // Register IDs
    localparam logic [3:0] c_RRSP  = 4'h4;
    localparam logic [3:0] c_RNONE = 4'hF;

    // W pipeline register contents
    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dstE;
        logic [63:0] valE;
        logic [3:0]  dstM;
        logic [63:0] valM;
    } w_reg_t;

    localparam w_reg_t c_W_BUBBLE = '{
        stat  : c_SBUB,
        icode : c_INOP,
        dstE  : c_RNONE,
        valE  : 64'd0,
        dstM  : c_RNONE,
        valM  : 64'd0
    };

    // True for the status codes that stop the machine
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == c_SHLT) || (stat == c_SADR) || (stat == c_SINS);
    endfunction

endpackage : writeback_pkg
`default_nettype wire

// File: rtl/wb_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : wb_perf_cnt
//  Description : Free-wrapping performance counter with count enable and
//                synchronous active-low clear.
//  Ports       : i_clk   - clock
//                i_rst_n - synchronous clear, active-low
//                i_en    - increment on this edge
//                o_count - current count (wraps modulo 2^CNT_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : wb_perf_cnt
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
//  Module      : writeback
//  Description : Y86-64 write-back (W) stage. Holds the W pipeline register,
//                drives register-file write ports / forwarding tags, freezes
//                the machine on halt or exception, reports processor status
//                and keeps retired-instruction and RUN-cycle counters.
//  Ports       : clk_i, rst_n_i         - clock, synchronous active-low reset
//                W_stall_i, W_bubble_i  - pipeline control for W
//                M_* / m_valM_i         - instruction arriving from memory
//                W_dst*_o, W_val*_o     - regfile write ports / forward tags
//                W_icode_o, W_stat_o    - raw W register contents
//                w_exc_o                - W holds HLT/ADR/INS
//                cpu_stat_o, halted_o   - architectural status
//                retired_o, cycles_o    - performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback
    import writeback_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             W_stall_i,
    input  logic             W_bubble_i,
    input  logic [2:0]       M_stat_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       M_dstE_i,
    input  logic [63:0]      M_valE_i,
    input  logic [3:0]       M_dstM_i,
    input  logic [63:0]      m_valM_i,
    output logic [3:0]       W_dstE_o,
    output logic [63:0]      W_valE_o,
    output logic [3:0]       W_dstM_o,
    output logic [63:0]      W_valM_o,
    output logic [3:0]       W_icode_o,
    output logic [2:0]       W_stat_o,
    output logic             w_exc_o,
    output logic [2:0]       cpu_stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } wb_state_e;

    wb_state_e r_state;
    wb_state_e w_state_nxt;
    w_reg_t    r_w;
    logic [2:0] r_frz_stat;
    logic       w_run;
    logic       w_retire;

    assign w_run = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Status FSM: leaves RUN on the edge where W carries the fault code,
    // then stays put until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUN) begin
            if (r_w.stat == c_SHLT) begin
                w_state_nxt = ST_HALT;
            end else if ((r_w.stat == c_SADR) || (r_w.stat == c_SINS)) begin
                w_state_nxt = ST_ERR;
            end
        end
    end

    // Status reported while frozen. It tracks W every RUN cycle, so on the
    // freezing edge it captures the fault code itself; anything loaded into
    // W on that same edge cannot disturb the reported status afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_frz_stat <= c_SAOK;
        end else if (w_run) begin
            r_frz_stat <= r_w.stat;
        end
    end

    // ------------------------------------------------------------------
    // W pipeline register: reset > frozen > stall > bubble > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_w <= c_W_BUBBLE;
        end else if (w_run && !W_stall_i) begin
            if (W_bubble_i) begin
                r_w <= c_W_BUBBLE;
            end else begin
                r_w <= '{
                    stat  : M_stat_i,
                    icode : M_icode_i,
                    dstE  : M_dstE_i,
                    valE  : M_valE_i,
                    dstM  : M_dstM_i,
                    valM  : m_valM_i
                };
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: only a healthy instruction in a running machine writes
    // ------------------------------------------------------------------
    assign W_dstE_o   = (w_run && (r_w.stat == c_SAOK)) ? r_w.dstE : c_RNONE;
    assign W_dstM_o   = (w_run && (r_w.stat == c_SAOK)) ? r_w.dstM : c_RNONE;
    assign W_valE_o   = r_w.valE;
    assign W_valM_o   = r_w.valM;
    assign W_icode_o  = r_w.icode;
    assign W_stat_o   = r_w.stat;
    assign w_exc_o    = is_exc(r_w.stat);
    assign halted_o   = !w_run;
    assign cpu_stat_o = !w_run                ? r_frz_stat :
                        (r_w.stat == c_SBUB)  ? c_SAOK     : r_w.stat;

    // An AOK instruction retires on the edge it leaves W, so a stalled one
    // is counted once, on release.
    assign w_retire = w_run && (r_w.stat == c_SAOK) && !W_stall_i;

    wb_perf_cnt #(.CNT_W(CNT_W)) u_retired_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_en    (w_retire),
        .o_count (retired_o)
    );

    wb_perf_cnt #(.CNT_W(CNT_W)) u_cycles_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_en    (w_run),
        .o_count (cycles_o)
    );

endmodule : writeback
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback
//  Description : Self-checking bench for writeback. Table of load/stall/
//                bubble vectors plus hand sequences for the exception, halt,
//                reset and counter-wrap corner cases. Expected outputs are
//                queued when stimulus is driven and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        W_stall_i, W_bubble_i;
    logic [2:0]  M_stat_i;
    logic [3:0]  M_icode_i, M_dstE_i, M_dstM_i;
    logic [63:0] M_valE_i, m_valM_i;

    logic [3:0]  W_dstE_o, W_dstM_o, W_icode_o;
    logic [63:0] W_valE_o, W_valM_o;
    logic [2:0]  W_stat_o, cpu_stat_o;
    logic        w_exc_o, halted_o;
    logic [63:0] retired_o, cycles_o;

    logic [3:0]  s_dstE_o, s_dstM_o, s_icode_o;
    logic [63:0] s_valE_o, s_valM_o;
    logic [2:0]  s_stat_o, s_cpu_stat_o;
    logic        s_exc_o, s_halted_o;
    logic [3:0]  s_retired_o, s_cycles_o;

    writeback #(.CNT_W(64)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .M_stat_i(M_stat_i), .M_icode_i(M_icode_i),
        .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i),
        .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
        .W_dstE_o(W_dstE_o), .W_valE_o(W_valE_o),
        .W_dstM_o(W_dstM_o), .W_valM_o(W_valM_o),
        .W_icode_o(W_icode_o), .W_stat_o(W_stat_o),
        .w_exc_o(w_exc_o), .cpu_stat_o(cpu_stat_o),
        .halted_o(halted_o), .retired_o(retired_o), .cycles_o(cycles_o)
    );

    // Narrow-counter instance for the wrap check
    writeback #(.CNT_W(4)) u_dut4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .M_stat_i(M_stat_i), .M_icode_i(M_icode_i),
        .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i),
        .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
        .W_dstE_o(s_dstE_o), .W_valE_o(s_valE_o),
        .W_dstM_o(s_dstM_o), .W_valM_o(s_valM_o),
        .W_icode_o(s_icode_o), .W_stat_o(s_stat_o),
        .w_exc_o(s_exc_o), .cpu_stat_o(s_cpu_stat_o),
        .halted_o(s_halted_o), .retired_o(s_retired_o), .cycles_o(s_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  de;  logic [63:0] ve;
        logic [3:0]  dm;  logic [63:0] vm;
        logic [3:0]  ic;  logic [2:0]  stat;
        logic [2:0]  cpu; logic        exc;
        logic        halt;
        logic [63:0] ret; logic [63:0] cyc;
    } exp_t;

    typedef struct {
        logic        st, bb;
        logic [2:0]  stat; logic [3:0] ic, de; logic [63:0] ve;
        logic [3:0]  dm;   logic [63:0] vm;
        logic [3:0]  x_de, x_dm, x_ic; logic [63:0] x_ve, x_vm;
        logic [2:0]  x_stat, x_cpu;   logic [63:0] x_ret;
    } vec_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_m(input logic [2:0] stat, input logic [3:0] ic,
                           input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm);
        M_stat_i = stat; M_icode_i = ic; M_dstE_i = de;
        M_valE_i = ve;   M_dstM_i = dm;  m_valM_i = vm;
    endtask

    function automatic exp_t mk_exp(input logic [3:0] de, input logic [63:0] ve,
                                    input logic [3:0] dm, input logic [63:0] vm,
                                    input logic [3:0] ic, input logic [2:0] stat,
                                    input logic [2:0] cpu, input logic exc,
                                    input logic halt, input logic [63:0] ret,
                                    input logic [63:0] cyc);
        exp_t e;
        e.de = de; e.ve = ve; e.dm = dm; e.vm = vm; e.ic = ic; e.stat = stat;
        e.cpu = cpu; e.exc = exc; e.halt = halt; e.ret = ret; e.cyc = cyc;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic st, input logic bb,
                                    input logic [2:0] stat, input logic [3:0] ic,
                                    input logic [3:0] de, input logic [63:0] ve,
                                    input logic [3:0] dm, input logic [63:0] vm,
                                    input logic [3:0] x_de, input logic [63:0] x_ve,
                                    input logic [3:0] x_dm, input logic [63:0] x_vm,
                                    input logic [3:0] x_ic, input logic [2:0] x_stat,
                                    input logic [63:0] x_ret);
        vec_t v;
        v.st = st; v.bb = bb; v.stat = stat; v.ic = ic; v.de = de; v.ve = ve;
        v.dm = dm; v.vm = vm; v.x_de = x_de; v.x_ve = x_ve; v.x_dm = x_dm;
        v.x_vm = x_vm; v.x_ic = x_ic; v.x_stat = x_stat;
        v.x_cpu = (x_stat == 3'd0) ? 3'd1 : x_stat;
        v.x_ret = x_ret;
        return v;
    endfunction

    // Pop the oldest expectation and compare every observable output
    task automatic check_pop(input string tag);
        exp_t e;
        n_tot++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue required entry", tag);
            return;
        end
        n_pass++;
        e = sb.pop_front();
        chk({tag, " dstE"},    64'(W_dstE_o),   64'(e.de));
        chk({tag, " valE"},    W_valE_o,        e.ve);
        chk({tag, " dstM"},    64'(W_dstM_o),   64'(e.dm));
        chk({tag, " valM"},    W_valM_o,        e.vm);
        chk({tag, " icode"},   64'(W_icode_o),  64'(e.ic));
        chk({tag, " stat"},    64'(W_stat_o),   64'(e.stat));
        chk({tag, " cpu_stat"},64'(cpu_stat_o), 64'(e.cpu));
        chk({tag, " exc"},     64'(w_exc_o),    64'(e.exc));
        chk({tag, " halted"},  64'(halted_o),   64'(e.halt));
        chk({tag, " retired"}, retired_o,       e.ret);
        chk({tag, " cycles"},  cycles_o,        e.cyc);
    endtask

    vec_t vt[10];
    exp_t e_rst;

    initial begin
        e_rst = mk_exp(4'hF, 0, 4'hF, 0, 4'h1, 3'd0, 3'd1, 1'b0, 1'b0, 0, 0);

        //           st bb stat ic    de    ve      dm    vm        | x_de  x_ve   x_dm  x_vm     x_ic  x_stat ret
        vt[0] = mk_vec(0, 0, 3'd1, 4'h3, 4'h3, 64'h55,  4'hF, 64'h0,    4'h3, 64'h55, 4'hF, 64'h0,    4'h3, 3'd1, 0);
        vt[1] = mk_vec(0, 0, 3'd1, 4'h5, 4'hF, 64'h100, 4'h2, 64'hABCD, 4'hF, 64'h100,4'h2, 64'hABCD, 4'h5, 3'd1, 1);
        vt[2] = mk_vec(1, 0, 3'd1, 4'h6, 4'h4, 64'h7,   4'hF, 64'h0,    4'hF, 64'h100,4'h2, 64'hABCD, 4'h5, 3'd1, 1);
        vt[3] = mk_vec(1, 0, 3'd1, 4'h6, 4'h4, 64'h7,   4'hF, 64'h0,    4'hF, 64'h100,4'h2, 64'hABCD, 4'h5, 3'd1, 1);
        vt[4] = mk_vec(1, 1, 3'd1, 4'h6, 4'h4, 64'h7,   4'hF, 64'h0,    4'hF, 64'h100,4'h2, 64'hABCD, 4'h5, 3'd1, 1);
        vt[5] = mk_vec(0, 0, 3'd1, 4'h6, 4'h4, 64'h7,   4'hF, 64'h0,    4'h4, 64'h7,  4'hF, 64'h0,    4'h6, 3'd1, 2);
        vt[6] = mk_vec(0, 1, 3'd1, 4'h2, 4'h9, 64'h9,   4'hF, 64'h0,    4'hF, 64'h0,  4'hF, 64'h0,    4'h1, 3'd0, 3);
        vt[7] = mk_vec(0, 0, 3'd1, 4'hB, 4'h5, 64'h8,   4'h5, 64'h99,   4'h5, 64'h8,  4'h5, 64'h99,   4'hB, 3'd1, 3);
        vt[8] = mk_vec(0, 1, 3'd1, 4'h3, 4'h1, 64'h1,   4'hF, 64'h0,    4'hF, 64'h0,  4'hF, 64'h0,    4'h1, 3'd0, 4);
        vt[9] = mk_vec(0, 0, 3'd0, 4'h1, 4'hF, 64'h0,   4'hF, 64'h0,    4'hF, 64'h0,  4'hF, 64'h0,    4'h1, 3'd0, 4);

        // ---------------- reset ----------------
        rst_n_i = 1'b0; W_stall_i = 1'b0; W_bubble_i = 1'b0;
        drive_m(3'd1, 4'h3, 4'h7, 64'hDEAD, 4'h6, 64'hBEEF);
        step(); step();
        sb.push_back(e_rst);
        check_pop("reset");
        rst_n_i = 1'b1;

        // ---------------- 17 RUN cycles: narrow counter wraps to 1 ----------------
        W_bubble_i = 1'b1;
        for (int i = 0; i < 17; i++) step();
        chk("wrap cycles4", 64'(s_cycles_o), 64'd1);
        chk("wrap retired4", 64'(s_retired_o), 64'd0);
        chk("wrap cycles64", cycles_o, 64'd17);
        W_bubble_i = 1'b0;

        // ---------------- table: load / stall / bubble ----------------
        for (int i = 0; i < 10; i++) begin
            W_stall_i  = vt[i].st;
            W_bubble_i = vt[i].bb;
            drive_m(vt[i].stat, vt[i].ic, vt[i].de, vt[i].ve, vt[i].dm, vt[i].vm);
            sb.push_back(mk_exp(vt[i].x_de, vt[i].x_ve, vt[i].x_dm, vt[i].x_vm,
                                vt[i].x_ic, vt[i].x_stat, vt[i].x_cpu, 1'b0, 1'b0,
                                vt[i].x_ret, 64'(18 + i)));
            step();
            check_pop($sformatf("vec%0d", i));
        end
        W_stall_i = 1'b0; W_bubble_i = 1'b0;

        // ---------------- address fault: writes gated, then ERR ----------------
        drive_m(3'd3, 4'h5, 4'hF, 64'h40, 4'h2, 64'h77);
        sb.push_back(mk_exp(4'hF, 64'h40, 4'hF, 64'h77, 4'h5, 3'd3, 3'd3, 1'b1, 1'b0, 4, 28));
        step();
        check_pop("adr_in_w");
        W_stall_i = 1'b1;
        drive_m(3'd1, 4'h3, 4'h1, 64'h11, 4'hF, 64'h0);
        sb.push_back(mk_exp(4'hF, 64'h40, 4'hF, 64'h77, 4'h5, 3'd3, 3'd3, 1'b1, 1'b1, 4, 29));
        step();
        check_pop("adr_frozen");
        W_stall_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_m(3'd1, 4'h6, 4'(i), 64'(i + 100), 4'hF, 64'h0);
            W_bubble_i = i[0];
            sb.push_back(mk_exp(4'hF, 64'h40, 4'hF, 64'h77, 4'h5, 3'd3, 3'd3, 1'b1, 1'b1, 4, 29));
            step();
            check_pop($sformatf("err_hold%0d", i));
        end
        W_bubble_i = 1'b0;

        rst_n_i = 1'b0;
        step();
        sb.push_back(e_rst);
        check_pop("reset_from_err");
        rst_n_i = 1'b1;

        // ---------------- halt sequence ----------------
        drive_m(3'd1, 4'h3, 4'h3, 64'h55, 4'hF, 64'h0);
        sb.push_back(mk_exp(4'h3, 64'h55, 4'hF, 64'h0, 4'h3, 3'd1, 3'd1, 1'b0, 1'b0, 0, 1));
        step();
        check_pop("irmovq");
        drive_m(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
        sb.push_back(mk_exp(4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 3'd2, 3'd2, 1'b1, 1'b0, 1, 2));
        step();
        check_pop("hlt_in_w");
        W_stall_i = 1'b1;
        drive_m(3'd1, 4'h6, 4'h2, 64'h33, 4'hF, 64'h0);
        sb.push_back(mk_exp(4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 3'd2, 3'd2, 1'b1, 1'b1, 1, 3));
        step();
        check_pop("halted");
        W_stall_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_m(3'd1, 4'h3, 4'(i + 1), 64'(i * 3 + 1), 4'(i), 64'(i + 7));
            W_bubble_i = i[1];
            sb.push_back(mk_exp(4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 3'd2, 3'd2, 1'b1, 1'b1, 1, 3));
            step();
            check_pop($sformatf("halt_hold%0d", i));
        end
        W_bubble_i = 1'b0;

        rst_n_i = 1'b0;
        step();
        sb.push_back(e_rst);
        check_pop("reset_from_halt");
        rst_n_i = 1'b1;

        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_writeback
`default_nettype wire
